// File: rtl/imem_boot_loader.sv
// Boot loader: assembles a little-endian program image from a byte stream and writes it
// word by word into instruction memory, holding the core in reset until the image is complete.
module imem_boot_loader #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned CNT_W = 11
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             rx_valid_i,
  input  logic [7:0]       rx_data_i,
  output logic             rx_ready_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  output logic             core_rst_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CNT_W-1:0] word_cnt_o
);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_LEN0  = 3'd1,
    S_LEN1  = 3'd2,
    S_DATA  = 3'd3,
    S_FLUSH = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic             rx_ready_q;
  logic             mem_we_q;
  logic [31:0]      mem_addr_q;
  logic [31:0]      mem_wdata_q;
  logic             core_rst_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [CNT_W-1:0] word_cnt_q;
  logic [1:0]       byte_idx_q;
  logic [15:0]      len_q;
  logic [23:0]      asm_q;

  logic             hs_s;
  logic             word_hs_s;
  logic             last_word_s;
  logic             rearm_s;
  logic [15:0]      len_new_s;

  // Next-state decode; word_hs_s marks the 4th byte of a word being accepted.
  always_comb begin
    state_d     = state_q;
    hs_s        = rx_valid_i && rx_ready_q;
    word_hs_s   = (state_q == S_DATA) && hs_s && (byte_idx_q == 2'd3);
    last_word_s = (16'(word_cnt_q) == (len_q - 16'd1));
    rearm_s     = start_i && ((state_q == S_DONE) || (state_q == S_ERR));
    len_new_s   = {rx_data_i, len_q[7:0]};
    case (state_q)
      S_BOOT: state_d = S_LEN0;
      S_LEN0: begin
        if (hs_s) state_d = S_LEN1;
        else      state_d = S_LEN0;
      end
      S_LEN1: begin
        if (!hs_s)                          state_d = S_LEN1;
        else if (len_new_s == 16'd0)        state_d = S_DONE;
        else if (len_new_s > 16'(DEPTH))    state_d = S_ERR;
        else                                state_d = S_DATA;
      end
      S_DATA: begin
        if (word_hs_s && last_word_s) state_d = S_FLUSH;
        else                          state_d = S_DATA;
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE, S_ERR: begin
        if (rearm_s) state_d = S_LEN0;
        else         state_d = state_q;
      end
      default: state_d = S_BOOT;
    endcase
  end

  // State, datapath and registered outputs; status flags follow the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_BOOT;
      rx_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      core_rst_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      word_cnt_q  <= '0;
      byte_idx_q  <= 2'd0;
      len_q       <= 16'd0;
      asm_q       <= 24'd0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= (state_d == S_LEN0) || (state_d == S_LEN1) || (state_d == S_DATA);
      busy_q     <= (state_d == S_LEN0) || (state_d == S_LEN1) ||
                    (state_d == S_DATA) || (state_d == S_FLUSH);
      done_q     <= (state_d == S_DONE);
      core_rst_q <= (state_d == S_DONE);
      err_q      <= (state_d == S_ERR);
      mem_we_q   <= word_hs_s;

      if ((state_q == S_LEN0) && hs_s) len_q[7:0]  <= rx_data_i;
      if ((state_q == S_LEN1) && hs_s) len_q[15:8] <= rx_data_i;

      if ((state_q == S_DATA) && hs_s) begin
        byte_idx_q <= byte_idx_q + 2'd1;
        case (byte_idx_q)
          2'd0: asm_q[7:0]   <= rx_data_i;
          2'd1: asm_q[15:8]  <= rx_data_i;
          2'd2: asm_q[23:16] <= rx_data_i;
          default: begin
            mem_wdata_q <= {rx_data_i, asm_q};
            mem_addr_q  <= {{(30-CNT_W){1'b0}}, word_cnt_q, 2'b00};
            word_cnt_q  <= word_cnt_q + CNT_W'(1);
          end
        endcase
      end

      if (rearm_s) begin
        word_cnt_q <= '0;
        byte_idx_q <= 2'd0;
      end
    end
  end

  assign rx_ready_o  = rx_ready_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign core_rst_o  = core_rst_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign word_cnt_o  = word_cnt_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: expected memory writes are queued as bytes are
// driven and checked against each write strobe.
module tb_imem_boot_loader;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned CNT_W = 11;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic             start = 1'b0;
  logic             rx_valid = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_ready_o, mem_we_o, core_rst_o, busy_o, done_o, err_o;
  logic [31:0]      mem_addr_o, mem_wdata_o;
  logic [CNT_W-1:0] word_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;
  int n_strobes = 0;
  int strobe_base;
  logic [63:0] exp_q[$];
  logic [63:0] exp_e;
  logic [7:0] img1 [10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h23, 8'h24, 8'h64, 8'h00};

  imem_boot_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
    .rx_ready_o(rx_ready_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .core_rst_o(core_rst_o), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .word_cnt_o(word_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_ni && mem_we_o) begin
      n_strobes++;
      if (exp_q.size() == 0) check("we_unexpected", 64'(exp_q.size()), 64'd1);
      else begin
        exp_e = exp_q.pop_front();
        check("we_word", {mem_addr_o, mem_wdata_o}, exp_e);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rx_ready_wait", 64'(rx_ready_o), 64'd1);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_img1(input int gap, input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      if (i > 0) repeat (gap) @(negedge clk);
      send_byte(img1[i]);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_ready"}, 64'(rx_ready_o), 64'd0);
    check({tag, "_mem_we"},   64'(mem_we_o),   64'd0);
    check({tag, "_addr"},     64'(mem_addr_o), 64'd0);
    check({tag, "_wdata"},    64'(mem_wdata_o), 64'd0);
    check({tag, "_core_rst"}, 64'(core_rst_o), 64'd0);
    check({tag, "_busy"},     64'(busy_o),     64'd0);
    check({tag, "_done"},     64'(done_o),     64'd0);
    check({tag, "_err"},      64'(err_o),      64'd0);
    check({tag, "_word_cnt"}, 64'(word_cnt_o), 64'd0);
  endtask

  task automatic check_flush_then_done(input string tag, input int words);
    check({tag, "_flush_busy"},  64'(busy_o),     64'd1);
    check({tag, "_flush_ready"}, 64'(rx_ready_o), 64'd0);
    check({tag, "_flush_done"},  64'(done_o),     64'd0);
    @(negedge clk);
    check({tag, "_done"},     64'(done_o),     64'd1);
    check({tag, "_core_rst"}, 64'(core_rst_o), 64'd1);
    check({tag, "_ready"},    64'(rx_ready_o), 64'd0);
    check({tag, "_busy"},     64'(busy_o),     64'd0);
    check({tag, "_we_low"},   64'(mem_we_o),   64'd0);
    check({tag, "_word_cnt"}, 64'(word_cnt_o), 64'(words));
  endtask

  initial begin
    // Reset state
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;

    // Two-word image, back-to-back bytes
    strobe_base = n_strobes;
    exp_q.push_back({32'h0000_0000, 32'h00A0_0513});
    exp_q.push_back({32'h0000_0004, 32'h0064_2423});
    send_img1(0, 10);
    check_flush_then_done("t1", 2);
    check("t1_strobes", 64'(n_strobes - strobe_base), 64'd2);

    // Re-arm, one-word image with a start pulse mid-DATA
    pulse_start();
    check("t6_core_rst", 64'(core_rst_o), 64'd0);
    check("t6_done",     64'(done_o),     64'd0);
    check("t6_word_cnt", 64'(word_cnt_o), 64'd0);
    check("t6_ready",    64'(rx_ready_o), 64'd1);
    strobe_base = n_strobes;
    exp_q.push_back({32'h0000_0000, 32'hDEAD_BEEF});
    send_byte(8'h01); send_byte(8'h00); send_byte(8'hEF); send_byte(8'hBE);
    pulse_start();
    check("t6_start_ign_busy",  64'(busy_o),     64'd1);
    check("t6_start_ign_ready", 64'(rx_ready_o), 64'd1);
    send_byte(8'hAD); send_byte(8'hDE);
    check_flush_then_done("t6", 1);
    check("t6_strobes", 64'(n_strobes - strobe_base), 64'd1);

    // Zero-length image
    pulse_start();
    strobe_base = n_strobes;
    send_byte(8'h00); send_byte(8'h00);
    check("t2_done",     64'(done_o),     64'd1);
    check("t2_core_rst", 64'(core_rst_o), 64'd1);
    check("t2_word_cnt", 64'(word_cnt_o), 64'd0);
    repeat (3) @(negedge clk);
    check("t2_strobes", 64'(n_strobes - strobe_base), 64'd0);

    // Oversized image (1025 words)
    pulse_start();
    strobe_base = n_strobes;
    send_byte(8'h01); send_byte(8'h04);
    check("t3_err",      64'(err_o),      64'd1);
    check("t3_ready",    64'(rx_ready_o), 64'd0);
    check("t3_core_rst", 64'(core_rst_o), 64'd0);
    check("t3_done",     64'(done_o),     64'd0);
    rx_valid = 1'b1;
    repeat (5) @(negedge clk);
    rx_valid = 1'b0;
    check("t3_strobes", 64'(n_strobes - strobe_base), 64'd0);
    check("t3_err_hold", 64'(err_o), 64'd1);

    // Two-word image with valid only every 3rd cycle
    pulse_start();
    check("t4_err_clear", 64'(err_o), 64'd0);
    strobe_base = n_strobes;
    exp_q.push_back({32'h0000_0000, 32'h00A0_0513});
    exp_q.push_back({32'h0000_0004, 32'h0064_2423});
    send_img1(2, 10);
    check_flush_then_done("t4", 2);
    check("t4_strobes", 64'(n_strobes - strobe_base), 64'd2);

    // Reset mid-load, then full reload
    pulse_start();
    exp_q.push_back({32'h0000_0000, 32'h00A0_0513});
    send_img1(0, 6);
    #2 rst_ni = 1'b0;
    #1;
    check_all_zero("t5_rst");
    strobe_base = n_strobes;
    @(negedge clk);
    check("t5_no_strobe", 64'(n_strobes - strobe_base), 64'd0);
    rst_ni = 1'b1;
    exp_q.push_back({32'h0000_0000, 32'h00A0_0513});
    exp_q.push_back({32'h0000_0004, 32'h0064_2423});
    send_img1(0, 10);
    check_flush_then_done("t5", 2);
    check("t5_strobes", 64'(n_strobes - strobe_base), 64'd2);

    @(negedge clk);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
